// File: rtl/systolic_matrix_ctrl.sv
// Sequencer for the 2x2 systolic array: latches one job, streams skewed operands
// with per-diagonal clear strobes, waits for the array to drain, then hands off results.
module systolic_matrix_ctrl #(
  parameter int unsigned K     = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 32,
  parameter int unsigned DRAIN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K*DW-1:0]      a_row1,
  input  logic [K*DW-1:0]      a_row2,
  input  logic [K*DW-1:0]      b_col1,
  input  logic [K*DW-1:0]      b_col2,
  output logic signed [DW-1:0] a1X,
  output logic signed [DW-1:0] a2X,
  output logic signed [DW-1:0] bX1,
  output logic signed [DW-1:0] bX2,
  output logic                 push11,
  output logic                 pushedge,
  output logic                 push22,
  input  logic signed [AW-1:0] c11,
  input  logic signed [AW-1:0] c12,
  input  logic signed [AW-1:0] c21,
  input  logic signed [AW-1:0] c22,
  output logic signed [AW-1:0] c11_out,
  output logic signed [AW-1:0] c12_out,
  output logic signed [AW-1:0] c21_out,
  output logic signed [AW-1:0] c22_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  // t runs across FEED (0..K) and DRAIN (K+1..K+DRAIN) so push22 can land in DRAIN when K=1
  localparam int unsigned TW = $clog2(K + DRAIN + 2);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_t, w_t_nxt;
  logic [K*DW-1:0] r_a1, r_a2, r_b1, r_b2;
  logic [K*DW-1:0] w_a1_src, w_a2_src, w_b1_src, w_b2_src;
  logic            w_accept, w_capture, w_feed_nxt, w_skew_ok;
  logic signed [DW-1:0] w_a1_nxt, w_a2_nxt, w_b1_nxt, w_b2_nxt;
  logic            w_push11_nxt, w_pushedge_nxt, w_push22_nxt;

  function automatic logic signed [DW-1:0] pick(input logic [K*DW-1:0] vec,
                                                input logic [TW-1:0]   idx);
    logic signed [DW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (idx == TW'(i)) v = vec[DW*i +: DW];
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_t_nxt     = '0;
          w_state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        w_t_nxt = r_t + TW'(1);
        if (r_t == TW'(K)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_t_nxt = r_t + TW'(1);
        if (r_t == TW'(K + DRAIN)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered, so they are computed for the cycle being entered;
    // on the accept edge the operands come straight from the ports.
    w_a1_src       = w_accept ? a_row1 : r_a1;
    w_a2_src       = w_accept ? a_row2 : r_a2;
    w_b1_src       = w_accept ? b_col1 : r_b1;
    w_b2_src       = w_accept ? b_col2 : r_b2;
    w_feed_nxt     = (w_state_nxt == S_FEED);
    w_skew_ok      = w_feed_nxt && (w_t_nxt != '0);
    w_a1_nxt       = w_feed_nxt ? pick(w_a1_src, w_t_nxt) : '0;
    w_b1_nxt       = w_feed_nxt ? pick(w_b1_src, w_t_nxt) : '0;
    w_a2_nxt       = w_skew_ok ? pick(w_a2_src, w_t_nxt - TW'(1)) : '0;
    w_b2_nxt       = w_skew_ok ? pick(w_b2_src, w_t_nxt - TW'(1)) : '0;
    w_push11_nxt   = w_feed_nxt && (w_t_nxt == TW'(0));
    w_pushedge_nxt = w_feed_nxt && (w_t_nxt == TW'(1));
    w_push22_nxt   = (w_feed_nxt || (w_state_nxt == S_DRAIN)) && (w_t_nxt == TW'(2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a1 <= '0;
      r_a2 <= '0;
      r_b1 <= '0;
      r_b2 <= '0;
    end else if (w_accept) begin
      r_a1 <= a_row1;
      r_a2 <= a_row2;
      r_b1 <= b_col1;
      r_b2 <= b_col2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      a1X       <= '0;
      a2X       <= '0;
      bX1       <= '0;
      bX2       <= '0;
      push11    <= 1'b0;
      pushedge  <= 1'b0;
      push22    <= 1'b0;
      c11_out   <= '0;
      c12_out   <= '0;
      c21_out   <= '0;
      c22_out   <= '0;
    end else begin
      in_ready  <= (w_state_nxt == S_IDLE);
      busy      <= (w_state_nxt != S_IDLE);
      out_valid <= (w_state_nxt == S_DONE);
      a1X       <= w_a1_nxt;
      a2X       <= w_a2_nxt;
      bX1       <= w_b1_nxt;
      bX2       <= w_b2_nxt;
      push11    <= w_push11_nxt;
      pushedge  <= w_pushedge_nxt;
      push22    <= w_push22_nxt;
      if (w_capture) begin
        c11_out <= c11;
        c12_out <= c12;
        c21_out <= c21;
        c22_out <= c22;
      end
    end
  end

endmodule

// File: tb/tb_systolic_matrix_ctrl.sv
// Directed bench for systolic_matrix_ctrl: K=2 and K=1 builds, each feeding a small
// behavioural 2x2 array, with hand-computed streams, strobes, latency and results.
module tb_systolic_matrix_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, out_ready, sel;
  logic [15:0] v_a1, v_a2, v_b1, v_b2;
  logic [7:0]  k1_a1, k1_a2, k1_b1, k1_b2;
  int n_checks = 0;
  int n_fail   = 0;

  // K=2 instance signals
  logic d2_in_ready, d2_push11, d2_pushedge, d2_push22, d2_out_valid, d2_busy;
  logic signed [DW-1:0] d2_a1X, d2_a2X, d2_bX1, d2_bX2;
  logic signed [AW-1:0] m2_c11, m2_c12, m2_c21, m2_c22;
  logic signed [AW-1:0] d2_c11o, d2_c12o, d2_c21o, d2_c22o;
  logic signed [DW-1:0] m2_a12, m2_b21, m2_a22, m2_b22;
  // K=1 instance signals
  logic d1_in_ready, d1_push11, d1_pushedge, d1_push22, d1_out_valid, d1_busy;
  logic signed [DW-1:0] d1_a1X, d1_a2X, d1_bX1, d1_bX2;
  logic signed [AW-1:0] m1_c11, m1_c12, m1_c21, m1_c22;
  logic signed [AW-1:0] d1_c11o, d1_c12o, d1_c21o, d1_c22o;
  logic signed [DW-1:0] m1_a12, m1_b21, m1_a22, m1_b22;

  systolic_matrix_ctrl #(.K(2), .DW(DW), .AW(AW), .DRAIN(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(d2_in_ready),
    .a_row1(v_a1), .a_row2(v_a2), .b_col1(v_b1), .b_col2(v_b2),
    .a1X(d2_a1X), .a2X(d2_a2X), .bX1(d2_bX1), .bX2(d2_bX2),
    .push11(d2_push11), .pushedge(d2_pushedge), .push22(d2_push22),
    .c11(m2_c11), .c12(m2_c12), .c21(m2_c21), .c22(m2_c22),
    .c11_out(d2_c11o), .c12_out(d2_c12o), .c21_out(d2_c21o), .c22_out(d2_c22o),
    .out_valid(d2_out_valid), .out_ready(out_ready), .busy(d2_busy));

  systolic_matrix_ctrl #(.K(1), .DW(DW), .AW(AW), .DRAIN(2)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(d1_in_ready),
    .a_row1(k1_a1), .a_row2(k1_a2), .b_col1(k1_b1), .b_col2(k1_b2),
    .a1X(d1_a1X), .a2X(d1_a2X), .bX1(d1_bX1), .bX2(d1_bX2),
    .push11(d1_push11), .pushedge(d1_pushedge), .push22(d1_push22),
    .c11(m1_c11), .c12(m1_c12), .c21(m1_c21), .c22(m1_c22),
    .c11_out(d1_c11o), .c12_out(d1_c12o), .c21_out(d1_c21o), .c22_out(d1_c22o),
    .out_valid(d1_out_valid), .out_ready(out_ready), .busy(d1_busy));

  function automatic logic signed [AW-1:0] mul(input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b);
    logic signed [AW-1:0] p;
    p = AW'(a) * AW'(b);
    return p;
  endfunction

  // Behavioural 2x2 array: A flows right, B flows down, one register per hop.
  always_ff @(posedge clk) begin
    if (reset) begin
      m2_a12 <= '0; m2_b21 <= '0; m2_a22 <= '0; m2_b22 <= '0;
      m2_c11 <= '0; m2_c12 <= '0; m2_c21 <= '0; m2_c22 <= '0;
      m1_a12 <= '0; m1_b21 <= '0; m1_a22 <= '0; m1_b22 <= '0;
      m1_c11 <= '0; m1_c12 <= '0; m1_c21 <= '0; m1_c22 <= '0;
    end else begin
      m2_a12 <= d2_a1X; m2_b21 <= d2_bX1; m2_a22 <= d2_a2X; m2_b22 <= d2_bX2;
      m2_c11 <= (d2_push11   ? '0 : m2_c11) + mul(d2_a1X, d2_bX1);
      m2_c12 <= (d2_pushedge ? '0 : m2_c12) + mul(m2_a12, d2_bX2);
      m2_c21 <= (d2_pushedge ? '0 : m2_c21) + mul(d2_a2X, m2_b21);
      m2_c22 <= (d2_push22   ? '0 : m2_c22) + mul(m2_a22, m2_b22);
      m1_a12 <= d1_a1X; m1_b21 <= d1_bX1; m1_a22 <= d1_a2X; m1_b22 <= d1_bX2;
      m1_c11 <= (d1_push11   ? '0 : m1_c11) + mul(d1_a1X, d1_bX1);
      m1_c12 <= (d1_pushedge ? '0 : m1_c12) + mul(m1_a12, d1_bX2);
      m1_c21 <= (d1_pushedge ? '0 : m1_c21) + mul(d1_a2X, m1_b21);
      m1_c22 <= (d1_push22   ? '0 : m1_c22) + mul(m1_a22, m1_b22);
    end
  end

  logic o_in_ready, o_push11, o_pushedge, o_push22, o_out_valid, o_busy;
  logic signed [DW-1:0] o_a1X, o_a2X, o_bX1, o_bX2;
  logic signed [AW-1:0] o_c11, o_c12, o_c21, o_c22;
  always_comb begin
    o_in_ready  = sel ? d1_in_ready  : d2_in_ready;
    o_push11    = sel ? d1_push11    : d2_push11;
    o_pushedge  = sel ? d1_pushedge  : d2_pushedge;
    o_push22    = sel ? d1_push22    : d2_push22;
    o_out_valid = sel ? d1_out_valid : d2_out_valid;
    o_busy      = sel ? d1_busy      : d2_busy;
    o_a1X       = sel ? d1_a1X       : d2_a1X;
    o_a2X       = sel ? d1_a2X       : d2_a2X;
    o_bX1       = sel ? d1_bX1       : d2_bX1;
    o_bX2       = sel ? d1_bX2       : d2_bX2;
    o_c11       = sel ? d1_c11o      : d2_c11o;
    o_c12       = sel ? d1_c12o      : d2_c12o;
    o_c21       = sel ? d1_c21o      : d2_c21o;
    o_c22       = sel ? d1_c22o      : d2_c22o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pack(input int a1[2], input int a2[2], input int b1[2], input int b2[2]);
    for (int i = 0; i < 2; i++) begin
      v_a1[8*i +: 8] = 8'(a1[i]);
      v_a2[8*i +: 8] = 8'(a2[i]);
      v_b1[8*i +: 8] = 8'(b1[i]);
      v_b2[8*i +: 8] = 8'(b2[i]);
    end
    k1_a1 = 8'(a1[0]); k1_a2 = 8'(a2[0]); k1_b1 = 8'(b1[0]); k1_b2 = 8'(b2[0]);
  endtask

  // mode 0: plain; 1: scramble operand ports after accept; 2: offer the next job while busy
  task automatic run_job(input string nm, input int a1[2], input int a2[2],
                         input int b1[2], input int b2[2],
                         input int e_a1[4], input int e_a2[4], input int e_b1[4],
                         input int e_b2[4], input int e_c[4], input int hold, input int mode);
    int k, cyc, n;
    k = sel ? 1 : 2;
    pack(a1, a2, b1, b2);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    n = 0;
    while (!o_in_ready && n < 50) begin step(); n++; end
    check_val({nm, "_accept_ready"}, o_in_ready, 1);
    step();
    cyc = 1;
    in_valid = 1'b0;
    if (mode == 1) begin
      v_a1 = 16'h7f7f; v_b1 = 16'h8181; k1_a1 = 8'h7f; k1_b1 = 8'h81;
    end else if (mode == 2) begin
      pack('{1, 1}, '{2, 2}, '{3, 3}, '{-1, -1});
      in_valid = 1'b1;
    end
    for (int t = 0; t <= k + 1; t++) begin
      check_val($sformatf("%s_a1X_t%0d", nm, t), o_a1X, e_a1[t]);
      check_val($sformatf("%s_a2X_t%0d", nm, t), o_a2X, e_a2[t]);
      check_val($sformatf("%s_bX1_t%0d", nm, t), o_bX1, e_b1[t]);
      check_val($sformatf("%s_bX2_t%0d", nm, t), o_bX2, e_b2[t]);
      check_val($sformatf("%s_push11_t%0d", nm, t), o_push11, (t == 0));
      check_val($sformatf("%s_pushedge_t%0d", nm, t), o_pushedge, (t == 1));
      check_val($sformatf("%s_push22_t%0d", nm, t), o_push22, (t == 2));
      check_val($sformatf("%s_busy_t%0d", nm, t), o_busy, 1);
      check_val($sformatf("%s_in_ready_t%0d", nm, t), o_in_ready, 0);
      if (t <= k) begin step(); cyc++; end
    end
    while (!o_out_valid && cyc < 40) begin step(); cyc++; end
    check_val({nm, "_out_valid"}, o_out_valid, 1);
    check_val({nm, "_latency"}, cyc, k + 4);
    check_val({nm, "_c11"}, o_c11, e_c[0]);
    check_val({nm, "_c12"}, o_c12, e_c[1]);
    check_val({nm, "_c21"}, o_c21, e_c[2]);
    check_val({nm, "_c22"}, o_c22, e_c[3]);
    for (int h = 0; h < hold; h++) begin
      step();
      check_val($sformatf("%s_hold_valid_%0d", nm, h), o_out_valid, 1);
      check_val($sformatf("%s_hold_in_ready_%0d", nm, h), o_in_ready, 0);
      check_val($sformatf("%s_hold_c11_%0d", nm, h), o_c11, e_c[0]);
      check_val($sformatf("%s_hold_c22_%0d", nm, h), o_c22, e_c[3]);
    end
    out_ready = 1'b1;
    step();
    check_val({nm, "_post_valid"}, o_out_valid, 0);
    check_val({nm, "_post_in_ready"}, o_in_ready, 1);
    check_val({nm, "_post_busy"}, o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    v_a1 = '0; v_a2 = '0; v_b1 = '0; v_b2 = '0;
    k1_a1 = '0; k1_a2 = '0; k1_b1 = '0; k1_b2 = '0;
    step(); step(); step();
    check_val("rst_in_ready", o_in_ready, 1);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_out_valid", o_out_valid, 0);
    check_val("rst_a1X", o_a1X, 0);
    check_val("rst_push11", o_push11, 0);
    check_val("rst_c11", o_c11, 0);
    reset = 1'b0;
    step();
    check_val("idle_in_ready", o_in_ready, 1);

    run_job("dflt", '{-6, 7}, '{1, -4}, '{-2, 9}, '{0, 1},
            '{-6, 7, 0, 0}, '{0, 1, -4, 0}, '{-2, 9, 0, 0}, '{0, 0, 1, 0},
            '{75, 7, -38, -4}, 0, 0);
    run_job("bp", '{-6, 7}, '{1, -4}, '{-2, 9}, '{0, 1},
            '{-6, 7, 0, 0}, '{0, 1, -4, 0}, '{-2, 9, 0, 0}, '{0, 0, 1, 0},
            '{75, 7, -38, -4}, 10, 0);
    run_job("b2b1", '{-6, 7}, '{1, -4}, '{-2, 9}, '{0, 1},
            '{-6, 7, 0, 0}, '{0, 1, -4, 0}, '{-2, 9, 0, 0}, '{0, 0, 1, 0},
            '{75, 7, -38, -4}, 0, 2);
    run_job("b2b2", '{1, 1}, '{2, 2}, '{3, 3}, '{-1, -1},
            '{1, 1, 0, 0}, '{0, 2, 2, 0}, '{3, 3, 0, 0}, '{0, -1, -1, 0},
            '{6, -2, 12, -4}, 0, 0);

    // Reset while FEED is at t=1
    pack('{-6, 7}, '{1, -4}, '{-2, 9}, '{0, 1});
    out_ready = 1'b1;
    check_val("mid_ready", o_in_ready, 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_val("mid_a1X_t1", o_a1X, 7);
    reset = 1'b1;
    step();
    check_val("mid_rst_a1X", o_a1X, 0);
    check_val("mid_rst_a2X", o_a2X, 0);
    check_val("mid_rst_bX1", o_bX1, 0);
    check_val("mid_rst_bX2", o_bX2, 0);
    check_val("mid_rst_pushedge", o_pushedge, 0);
    check_val("mid_rst_in_ready", o_in_ready, 1);
    check_val("mid_rst_busy", o_busy, 0);
    reset = 1'b0;
    step();
    run_job("after_rst", '{-6, 7}, '{1, -4}, '{-2, 9}, '{0, 1},
            '{-6, 7, 0, 0}, '{0, 1, -4, 0}, '{-2, 9, 0, 0}, '{0, 0, 1, 0},
            '{75, 7, -38, -4}, 0, 0);
    run_job("opchg", '{-6, 7}, '{1, -4}, '{-2, 9}, '{0, 1},
            '{-6, 7, 0, 0}, '{0, 1, -4, 0}, '{-2, 9, 0, 0}, '{0, 0, 1, 0},
            '{75, 7, -38, -4}, 0, 1);

    sel = 1'b1;
    step();
    run_job("k1", '{5, 0}, '{-3, 0}, '{2, 0}, '{4, 0},
            '{5, 0, 0, 0}, '{0, -3, 0, 0}, '{2, 0, 0, 0}, '{0, 4, 0, 0},
            '{10, 20, -6, -12}, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_matrix_ctrl.md
Name: systolic_matrix_ctrl

Overview:
Sequencer for the 2x2 int8 systolic_matrix array. Accepts one job: a 2xK A matrix and a Kx2 B matrix, loaded through a valid/ready handshake. It drives the skewed operand streams (a1X, a2X, bX1, bX2) and the per-diagonal accumulator-clear strobes (push11, pushedge, push22), waits for the array to drain, then captures c11..c22 and presents them through a valid/ready result handshake.

Parameters:
K, 2, inner dimension (number of MAC steps per PE); legal range 1..16
DW, 8, operand width (signed)
AW, 32, accumulator/result width (signed)
DRAIN, 2, cycles waited after the last feed cycle before capturing results

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  job offered
in_ready  out  1  controller can accept a job
a_row1  in  K*DW  A row 1; element k is at bits [DW*k+DW-1:DW*k]
a_row2  in  K*DW  A row 2, same packing
b_col1  in  K*DW  B column 1, same packing
b_col2  in  K*DW  B column 2, same packing
a1X, a2X, bX1, bX2  out  DW each  signed operand streams to the array
push11, pushedge, push22  out  1 each  accumulator-clear strobes for PE11, PE12/PE21, PE22
c11, c12, c21, c22  in  AW each  array accumulator outputs
c11_out, c12_out, c21_out, c22_out  out  AW each  captured results
out_valid  out  1  results valid
out_ready  in  1  consumer accepts results
busy  out  1  high in any state except IDLE

Behaviour:
- All outputs are registered. Reset (synchronous, active-high) drives the FSM to IDLE; all streams, strobes, c*_out, out_valid and busy are 0, and in_ready is 1. A reset during any state aborts the job and discards its operands.
- FSM states: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch all four operand vectors, clear cycle counter t, and go to FEED.
- FEED: lasts K+1 cycles, t=0..K. During cycle t:
  - a1X=A1[t] and bX1=B1[t] when t<K; otherwise 0.
  - a2X=A2[t-1] and bX2=B2[t-1] when 1<=t<=K; otherwise 0.
  - This is the one-cycle skew for row 2 and column 2.
- Strobes are single-cycle:
  - push11 is high at t=0.
  - pushedge is high at t=1.
  - push22 is high at t=2. When K=1, push22 is high in the first DRAIN cycle instead.
  - An asserted strobe makes the PE load its product instead of accumulating.
- After t=K, go to DRAIN. All streams and strobes are 0 in DRAIN.
- DRAIN: lasts DRAIN cycles. At the final DRAIN edge, register c11..c22 into c*_out, set out_valid=1, and go to DONE.
- DONE: c*_out and out_valid are held stable until out_valid&out_ready. On that edge, clear out_valid and go to IDLE. in_ready is 0 in DONE; there is no overlap of jobs.
- Latency from the accept edge to out_valid rising is K+2+DRAIN cycles (6 with the defaults). Minimum job period is K+3+DRAIN cycles.
- in_valid while busy is ignored; the upstream must hold the job until it sees in_ready.
- out_ready asserted while out_valid=0 has no effect.
- Operands are latched at accept; changes to the input vectors during FEED do not affect the streams.
- Arithmetic: no arithmetic is performed in this block. Operands pass through unchanged, signed, DW bits wide.

Test Plan:
- Default job: A1=[-6,7], A2=[1,-4], B1=[-2,9], B2=[0,1], array instantiated, out_ready=1.
  - Streams over FEED t=0..2: a1X=-6,7,0; a2X=0,1,-4; bX1=-2,9,0; bX2=0,0,1.
  - push11, pushedge, push22 pulse at t=0,1,2.
  - out_valid rises 6 cycles after accept with c11_out=75, c12_out=7, c21_out=-38, c22_out=-4.
- Back-pressure: same job with out_ready=0 for 10 cycles after out_valid.
  - Outputs are held stable and in_ready=0 throughout.
  - When out_ready is raised, the FSM returns to IDLE the next cycle.
- Back-to-back jobs: second job A1=[1,1], A2=[2,2], B1=[3,3], B2=[-1,-1] offered while busy.
  - The job is accepted only after the first result handshake.
  - Results are 6, -2, 12, -4, showing the strobes cleared the old accumulations.
- Reset mid-FEED: assert reset at t=1.
  - The next cycle shows all streams 0, in_ready=1, busy=0.
  - A fresh job then completes correctly.
- Operand change during FEED: vary a_row1 and b_col1 after accept; the streams must match the latched values only.
- K=1 build: A1=[5], A2=[-3], B1=[2], B2=[4].
  - Streams: a1X=5,0; a2X=0,-3; bX1=2,0; bX2=0,4.
  - Results are 10, 20, -6, -12, with latency 5.
